apb_master_ctrl: RTL
====================

// Module: apb_master_ctrl
// PURPOSE
//  APB initiator that bridges processor-side requests onto the shared APB bus that feeds
//  the two APB_Slave instances (slave ids ID1/ID2).
//  Accepts one request at a time and runs the APB SETUP/ACCESS phases.
//  Muxes the selected slave's ready/rdata back to the processor.
//  Reports completion (pm_stable) and the error of an invalid select or timeout (pm_error).
// PARAMETERS
//  ID1      2'b01  select code answered by slave 1
//  ID2      2'b10  select code answered by slave 2
//  TIMEOUT  64     max ACCESS cycles waiting for ready before abort (>=2)
// PORTS
//  clk              in   1  system clock
//  reset            in   1  synchronous, active-high reset
//  pm_start         in   1  request strobe, sampled only in IDLE
//  pm_write         in   1  1=write, 0=read
//  pm_sel           in   2  target slave id
//  pm_addr          in   8  target address
//  pm_wdata         in   8  write data
//  pm_wait_cycles   in   8  wait states requested of slave, forwarded unchanged
//  pm_rdata         out  8  read data of last successful read
//  pm_stable        out  1  1-cycle completion pulse
//  pm_error         out  1  qualifies pm_stable: invalid sel or timeout
//  apb_sel          out  2  broadcast select, 2'b00 = no slave
//  apb_enable       out  1  APB enable (ACCESS phase)
//  apb_write        out  1  APB direction
//  apb_addr         out  8  APB address
//  apb_wdata        out  8  APB write data
//  apb_wait_cycles  out  8  wait-state count to slave
//  apb1_ready       in   1  slave 1 ready
//  apb1_rdata       in   8  slave 1 read data
//  apb2_ready       in   1  slave 2 ready
//  apb2_rdata       in   8  slave 2 read data
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; timeout counter 0.
//    Reset mid-transfer aborts on the next edge with no pm_stable.
//  - FSM:
//    IDLE -> SETUP when pm_start=1 and pm_sel is ID1 or ID2.
//    IDLE -> DONE (pm_error=1, no bus activity) when pm_start=1 and pm_sel is anything else.
//    SETUP -> ACCESS unconditionally.
//    ACCESS -> DONE on selected ready=1 or on timeout.
//    DONE -> IDLE.
//  - In IDLE, pm_* inputs are latched into request regs; pm_start in other states is ignored.
//  - SETUP: apb_sel=latched sel; apb_enable=0; apb_write/addr/wdata/wait_cycles driven from the latch.
//  - ACCESS: apb_enable=1; all APB outputs held stable; ready/rdata taken only from the selected slave.
//  - IDLE and DONE: apb_sel=0 and apb_enable=0; apb_write/addr/wdata/wait_cycles hold their last values.
//  - Success: on ready=1 in ACCESS, a read captures the selected rdata into pm_rdata at that edge.
//    pm_rdata is unchanged by writes and errors.
//  - Latency: with ready high in the first ACCESS cycle, pm_stable is high 3 cycles after the
//    pm_start sample edge. Each ACCESS cycle with ready low adds 1 cycle.
//  - Timeout: counter cleared on SETUP->ACCESS and incremented on each ACCESS cycle with ready=0.
//    When counter==TIMEOUT-1 and ready=0: go to DONE with pm_error=1.
//    ACCESS therefore lasts at most TIMEOUT cycles. A ready arriving in that same final cycle wins.
//  - pm_stable/pm_error are high only in DONE (exactly 1 cycle).
//  - Back-to-back: next pm_start is accepted in the IDLE cycle after DONE.
// STRUCTURE
//  - apb_pkg: state enum {IDLE,SETUP,ACCESS,DONE}, SEL_NONE=2'b00, 8-bit data/addr width constants.
//  - Sub-module apb_rsp_mux: combinational mux from sel to ready/rdata; 0 for unmatched sel.
//  - Timeout counter width $clog2(TIMEOUT+1).
// TESTING
//  1. Write sel=ID1 addr=8'h10 wdata=8'hA5, apb1_ready high in ACCESS
//     -> SETUP then ACCESS with enable=1; pm_stable 3 cycles after start; pm_error=0.
//  2. Read sel=ID2 addr=8'h04, apb2_ready high after 3 low cycles, apb2_rdata=8'h3C
//     -> pm_rdata=8'h3C; pm_stable 6 cycles after start.
//  3. Read sel=ID1 with apb2_ready=1 and apb1_ready=0 forever, TIMEOUT=64
//     -> 64 ACCESS cycles, then pm_stable=1 with pm_error=1; pm_rdata unchanged.
//  4. pm_start with sel=2'b11 -> apb_sel stays 0; pm_stable=1 and pm_error=1 one cycle after start.
//  5. Assert reset during ACCESS -> next edge: apb_enable=0, apb_sel=0, state IDLE, no pm_stable.
//  6. pm_start held high for 10 cycles -> transfers run back-to-back with one IDLE cycle between
//     pm_stable pulses; start pulses during SETUP/ACCESS are ignored.

Source files
------------

// File: rtl/apb_master_ctrl_pkg.sv
// Shared types and constants for the APB initiator: FSM states, request
// record and bus widths.
package apb_master_ctrl_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam logic [1:0] SEL_NONE = 2'b00;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  typedef struct packed {
    logic              write;
    logic [1:0]        sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] wait_cycles;
  } req_t;

  function automatic logic sel_valid(input logic [1:0] sel,
                                     input logic [1:0] id1,
                                     input logic [1:0] id2);
    return (sel == id1) || (sel == id2);
  endfunction
endpackage

// File: rtl/apb_master_ctrl_if.sv
// Processor-side request/response plus the shared APB bus and the two
// slave response channels.
interface apb_master_ctrl_if;
  import apb_master_ctrl_pkg::*;

  logic              pm_start;
  logic              pm_write;
  logic [1:0]        pm_sel;
  logic [ADDR_W-1:0] pm_addr;
  logic [DATA_W-1:0] pm_wdata;
  logic [DATA_W-1:0] pm_wait_cycles;
  logic [DATA_W-1:0] pm_rdata;
  logic              pm_stable;
  logic              pm_error;

  logic [1:0]        apb_sel;
  logic              apb_enable;
  logic              apb_write;
  logic [ADDR_W-1:0] apb_addr;
  logic [DATA_W-1:0] apb_wdata;
  logic [DATA_W-1:0] apb_wait_cycles;
  logic              apb1_ready;
  logic [DATA_W-1:0] apb1_rdata;
  logic              apb2_ready;
  logic [DATA_W-1:0] apb2_rdata;

  modport master (
    input  pm_start, pm_write, pm_sel, pm_addr, pm_wdata, pm_wait_cycles,
    output pm_rdata, pm_stable, pm_error,
    output apb_sel, apb_enable, apb_write, apb_addr, apb_wdata, apb_wait_cycles,
    input  apb1_ready, apb1_rdata, apb2_ready, apb2_rdata
  );

  modport slave (
    output pm_start, pm_write, pm_sel, pm_addr, pm_wdata, pm_wait_cycles,
    input  pm_rdata, pm_stable, pm_error,
    input  apb_sel, apb_enable, apb_write, apb_addr, apb_wdata, apb_wait_cycles,
    output apb1_ready, apb1_rdata, apb2_ready, apb2_rdata
  );
endinterface

// File: rtl/apb_master_ctrl_rsp_mux.sv
// Selects ready/rdata of the addressed slave; an unmatched select yields
// a quiet (all-zero) response.
module apb_rsp_mux
  import apb_master_ctrl_pkg::*;
#(
  parameter logic [1:0] ID1 = 2'b01,
  parameter logic [1:0] ID2 = 2'b10
) (
  input  logic [1:0]        sel,
  input  logic              apb1_ready,
  input  logic [DATA_W-1:0] apb1_rdata,
  input  logic              apb2_ready,
  input  logic [DATA_W-1:0] apb2_rdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata
);
  always_comb begin
    ready = 1'b0;
    rdata = '0;
    if (sel == ID1) begin
      ready = apb1_ready;
      rdata = apb1_rdata;
    end else if (sel == ID2) begin
      ready = apb2_ready;
      rdata = apb2_rdata;
    end
  end
endmodule

// File: rtl/apb_master_ctrl.sv
// APB initiator: one request at a time through SETUP/ACCESS, with a bounded
// wait for ready and a single-cycle completion/error report.
module apb_master_ctrl
  import apb_master_ctrl_pkg::*;
#(
  parameter logic [1:0] ID1     = 2'b01,
  parameter logic [1:0] ID2     = 2'b10,
  parameter int         TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  apb_master_ctrl_if.master    bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  state_t            state, state_nxt;
  req_t              req_q;
  logic [CW-1:0]     tcnt;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              start_ok;
  logic              active;

  assign start_ok = sel_valid(bus.pm_sel, ID1, ID2);

  apb_rsp_mux #(.ID1(ID1), .ID2(ID2)) u_rsp_mux (
    .sel        (req_q.sel),
    .apb1_ready (bus.apb1_ready),
    .apb1_rdata (bus.apb1_rdata),
    .apb2_ready (bus.apb2_ready),
    .apb2_rdata (bus.apb2_rdata),
    .ready      (rsp_ready),
    .rdata      (rsp_rdata)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.pm_start) state_nxt = start_ok ? SETUP : DONE;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (rsp_ready || tcnt == TLAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      req_q   <= '0;
      tcnt    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (bus.pm_start) begin
          err_q <= !start_ok;
          // Invalid selects never reach the bus, so the APB fields keep
          // whatever the last real transfer drove.
          if (start_ok)
            req_q <= '{write: bus.pm_write, sel: bus.pm_sel, addr: bus.pm_addr,
                       wdata: bus.pm_wdata, wait_cycles: bus.pm_wait_cycles};
        end
        SETUP: tcnt <= '0;
        ACCESS: begin
          if (rsp_ready) begin
            err_q <= 1'b0;
            if (!req_q.write) rdata_q <= rsp_rdata;
          end else if (tcnt == TLAST) begin
            err_q <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign active              = (state == SETUP) || (state == ACCESS);
  assign bus.apb_sel         = active ? req_q.sel : SEL_NONE;
  assign bus.apb_enable      = (state == ACCESS);
  assign bus.apb_write       = req_q.write;
  assign bus.apb_addr        = req_q.addr;
  assign bus.apb_wdata       = req_q.wdata;
  assign bus.apb_wait_cycles = req_q.wait_cycles;
  assign bus.pm_rdata        = rdata_q;
  assign bus.pm_stable       = (state == DONE);
  assign bus.pm_error        = (state == DONE) && err_q;
endmodule
